// File: rtl/nanao_pkg.sv
// Shared types for the NANAO tile shifter.
//   pixel_code_t    : 8-bit pixel code {palette bank, pen}
//   tile_row_t      : one 8-pixel tile row (4 bitplanes, palette bank, flip)
//   shifter_state_t : shifter FSM states
//   CNT_W           : width of the pixel-pair counter (4 pairs per row)
package nanao_pkg;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic [3:0] bank;
        logic [3:0] pen;
    } pixel_code_t;

    typedef struct packed {
        logic [7:0] pl3;
        logic [7:0] pl2;
        logic [7:0] pl1;
        logic [7:0] pl0;
        logic [3:0] attr;
        logic       flip;
    } tile_row_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } shifter_state_t;

endpackage

// File: rtl/nanao_tile_pair_sel.sv
// Combinational pixel-pair extractor.
// Picks pixels 2*cnt (even) and 2*cnt+1 (odd) out of a tile row and
// forms their {bank, pen} codes, honouring the horizontal flip.
//   row      : tile row (planes, palette bank, flip)
//   cnt      : pair index 0..3
//   pix_even : code of pixel 2*cnt
//   pix_odd  : code of pixel 2*cnt+1
module nanao_tile_pair_sel
    import nanao_pkg::*;
(
    input  tile_row_t        row,
    input  logic [CNT_W-1:0] cnt,
    output pixel_code_t      pix_even,
    output pixel_code_t      pix_odd
);

    // Bit 7 of each plane is the leftmost pixel; flipping mirrors the row,
    // so pixel i reads bit i instead of bit 7-i.
    function automatic logic [3:0] pen_at(input tile_row_t r, input logic [2:0] i);
        logic [2:0] b;
        b = r.flip ? i : (3'd7 - i);
        return {r.pl3[b], r.pl2[b], r.pl1[b], r.pl0[b]};
    endfunction

    logic [2:0] idx_even;
    logic [2:0] idx_odd;

    assign idx_even = {cnt, 1'b0};
    assign idx_odd  = {cnt, 1'b1};

    assign pix_even = {row.attr, pen_at(row, idx_even)};
    assign pix_odd  = {row.attr, pen_at(row, idx_odd)};

endmodule

// File: rtl/nanao_tile_shifter.sv
// NANAO tile shifter: double-buffered 8-pixel tile-row shifter emitting one
// even/odd pixel pair per enabled clock.
//   CLK, RST        : clock, synchronous active-high reset
//   CE              : clock enable (0 freezes everything, blocks loads)
//   LINE_START      : flush to idle/blank, clears UNDERRUN
//   LD, PL0..PL3,
//   ATTR, FLIPX     : tile-row load into the holding register
//   LD_REQ          : holding register empty, LD will be accepted
//   DA, DB          : registered even/odd pixel codes {bank, pen}
//   UNDERRUN        : sticky, a tile ended with no successor loaded
module nanao_tile_shifter
    import nanao_pkg::*;
#(
    parameter logic [7:0] BLANK_CODE = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic       LINE_START,
    input  logic       LD,
    input  logic [7:0] PL0,
    input  logic [7:0] PL1,
    input  logic [7:0] PL2,
    input  logic [7:0] PL3,
    input  logic [3:0] ATTR,
    input  logic       FLIPX,
    output logic       LD_REQ,
    output logic [7:0] DA,
    output logic [7:0] DB,
    output logic       UNDERRUN
);

    shifter_state_t   state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             hold_vld, hold_vld_n;
    tile_row_t        hold, hold_n;
    tile_row_t        active, active_n;
    logic [7:0]       da_n, db_n;
    logic             underrun_n;

    tile_row_t        ld_row;
    pixel_code_t      pix_even;
    pixel_code_t      pix_odd;

    assign ld_row = {PL3, PL2, PL1, PL0, ATTR, FLIPX};
    assign LD_REQ = !hold_vld;

    nanao_tile_pair_sel u_pair_sel (
        .row      (active),
        .cnt      (cnt),
        .pix_even (pix_even),
        .pix_odd  (pix_odd)
    );

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hold_vld_n = hold_vld;
        hold_n     = hold;
        active_n   = active;
        da_n       = DA;
        db_n       = DB;
        underrun_n = UNDERRUN;

        if (CE) begin
            if (LINE_START) begin
                hold_vld_n = 1'b0;
                state_n    = ST_IDLE;
                cnt_n      = '0;
                da_n       = BLANK_CODE;
                db_n       = BLANK_CODE;
                underrun_n = 1'b0;
            end else begin
                // A load is only taken into an empty holding register, so it
                // can never collide with a HOLD->ACTIVE transfer below.
                if (LD && !hold_vld) begin
                    hold_n     = ld_row;
                    hold_vld_n = 1'b1;
                end

                case (state)
                    ST_IDLE: begin
                        da_n = BLANK_CODE;
                        db_n = BLANK_CODE;
                        if (hold_vld) begin
                            active_n   = hold;
                            hold_vld_n = 1'b0;
                            cnt_n      = '0;
                            state_n    = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        da_n  = pix_even;
                        db_n  = pix_odd;
                        cnt_n = cnt + CNT_W'(1);
                        // Last pair: chain straight into the next row if one
                        // is waiting, otherwise drop to idle and flag it.
                        if (cnt == {CNT_W{1'b1}}) begin
                            cnt_n = '0;
                            if (hold_vld) begin
                                active_n   = hold;
                                hold_vld_n = 1'b0;
                            end else begin
                                state_n    = ST_IDLE;
                                underrun_n = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_n = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hold_vld <= 1'b0;
            DA       <= BLANK_CODE;
            DB       <= BLANK_CODE;
            UNDERRUN <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hold_vld <= hold_vld_n;
            DA       <= da_n;
            DB       <= db_n;
            UNDERRUN <= underrun_n;
        end
    end

    // Tile data registers carry no reset; their valid/state bits gate use.
    always_ff @(posedge CLK) begin
        hold   <= hold_n;
        active <= active_n;
    end

endmodule

// File: doc/nanao_tile_shifter.md
NANAO_TILE_SHIFTER -- requirements
Module: nanao_tile_shifter

Interface
REQ-001 Parameter: BLANK_CODE, default 8'h00, 8-bit code driven on DA/DB while no tile is active.
REQ-002 CLK  in  1  pixel-pair clock; one even/odd pixel pair per enabled cycle.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 CE  in  1  clock enable; when 0 all state and outputs hold.
REQ-005 LINE_START  in  1  flush strobe at start of line.
REQ-006 LD  in  1  load strobe; PL0..PL3/ATTR/FLIPX valid when high.
REQ-007 PL0, PL1, PL2, PL3  in  8 each  bitplane bytes, bit7 = leftmost pixel, PL3 = pen MSB.
REQ-008 ATTR  in  4  palette bank for the tile row.
REQ-009 FLIPX  in  1  horizontal flip for the tile row.
REQ-010 LD_REQ  out  1  high when the holding register is empty and LD will be accepted.
REQ-011 DA  out  8  even pixel {ATTR, pen}, registered; feeds the layer mux DA0/DA1 input.
REQ-012 DB  out  8  odd pixel {ATTR, pen}, registered; feeds the layer mux DB0/DB1 input.
REQ-013 UNDERRUN  out  1  sticky flag: tile ended with no successor loaded.

Function
REQ-014 The block SHALL hold two 8-pixel tile rows: HOLD (with valid bit) and ACTIVE, plus a 2-bit pair counter CNT.
REQ-015 State machine: IDLE (no active tile, DA=DB=BLANK_CODE) and RUN (ACTIVE shifting).
REQ-016 LD_REQ SHALL equal !HOLD_valid and SHALL be combinational from registered state only.
REQ-017 On an enabled edge with LD=1 and LD_REQ=1, HOLD SHALL capture PL0..PL3, ATTR, FLIPX and set HOLD_valid; LD with LD_REQ=0 SHALL be ignored.
REQ-018 In IDLE with HOLD_valid, the next enabled edge SHALL move HOLD to ACTIVE, clear HOLD_valid, set CNT=0, enter RUN.
REQ-019 In RUN, each enabled edge SHALL register DA=pixel(2*CNT), DB=pixel(2*CNT+1) and increment CNT modulo 4.
REQ-020 Pen of pixel i (unflipped) SHALL be {PL3[7-i],PL2[7-i],PL1[7-i],PL0[7-i]}; with FLIPX=1, pixel i SHALL use bit index i instead of 7-i.
REQ-021 Latency: LD sampled at enabled edge t from IDLE → pair 0 on DA/DB after edge t+2, pairs 1..3 after t+3..t+5.
REQ-022 At CNT=3 with HOLD_valid, the same edge SHALL emit pair 3, load ACTIVE from HOLD, set CNT=0 (seamless, no gap pixels).
REQ-023 At CNT=3 with HOLD empty, the edge SHALL emit pair 3, enter IDLE and set UNDERRUN; DA/DB=BLANK_CODE from the next edge.
REQ-024 LD on the same edge as a HOLD→ACTIVE transfer SHALL NOT be accepted (LD_REQ was 0).
REQ-025 LINE_START=1 on an enabled edge SHALL clear HOLD_valid, enter IDLE, set CNT=0, drive BLANK_CODE, clear UNDERRUN; it overrides a simultaneous LD.
REQ-026 CE=0 SHALL freeze CNT, HOLD, ACTIVE, state, outputs and SHALL block LD acceptance.

Reset
REQ-027 RST SHALL take priority over CE and LINE_START.
REQ-028 Reset values: state IDLE, CNT=0, HOLD_valid=0, DA=DB=BLANK_CODE, UNDERRUN=0, LD_REQ=1.
REQ-029 HOLD/ACTIVE data contents need no reset.

Structure
REQ-030 Package nanao_pkg SHALL hold pixel_code_t (8-bit {bank,pen}), tile_row_t (4 planes, attr, flip) and the pair-count width constant.
REQ-031 Sub-module nanao_tile_pair_sel SHALL combinationally extract the pixel pair for a tile_row_t and CNT, including flip.

Verification
REQ-032 Reset, idle: RST then 4 cycles → DA=DB=8'h00, LD_REQ=1, UNDERRUN=0.
REQ-033 Single tile: PL0=8'hAA, PL1..3=0, ATTR=4'h5, FLIPX=0 → DA=8'h51, DB=8'h50 for 4 pairs from t+2, then UNDERRUN=1, blank.
REQ-034 Flip: PL0=8'h80, FLIPX=1, ATTR=4'h2 → pairs (20,20),(20,20),(20,20),(20,21).
REQ-035 Back-to-back: second LD while first tile runs → 8 consecutive pairs, no blank gap, UNDERRUN=0.
REQ-036 CE gating: CE=0 for 3 cycles mid-tile → outputs and CNT held, sequence resumes unchanged.
REQ-037 LINE_START with LD same edge mid-tile → blank next edge, HOLD empty, LD_REQ=1, UNDERRUN cleared.
